imm_gen_pipe: RTL and testbench

//  Parametrised, pipelined immediate generator for the RV decode stage. Decodes full opcode[6:0],

---
 rtl/imm_gen_pkg.sv | 31 +++
 rtl/imm_gen_if.sv | 24 ++
 rtl/imm_decode.sv | 48 ++++
 rtl/imm_gen_pipe.sv | 94 +++++++++
 tb/tb_imm_gen_pipe.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_gen_pkg.sv
// Shared definitions for the pipelined immediate generator: opcodes, format codes
// and occupancy states.
package imm_gen_pkg;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/imm_gen_if.sv
// Fetch-side and ALU-side handshake bundle of the immediate generator.
interface imm_gen_if #(parameter int XLEN = 64);
  // valid/ready: a word moves on a rising edge where valid and ready are both 1;
  // the sender keeps its payload stable while valid=1 and ready=0.
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;
  logic [31:0]     out_instr;

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_instr
  );

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_instr
  );
endinterface

// File: rtl/imm_decode.sv
// Combinational RV immediate decoder: builds a 32-bit signed immediate per format
// and sign-extends it to XLEN.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);

  logic signed [31:0] imm32;

  always_comb begin
    imm32   = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (instr[6:0])
      OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_JALR, OPC_SYSTEM: begin
        fmt   = FMT_I;
        imm32 = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_STORE: begin
        fmt   = FMT_S;
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        fmt   = FMT_B;
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt   = FMT_U;
        imm32 = {instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        fmt   = FMT_J;
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: illegal = 1'b1;
    endcase
  end

  // Signed size cast: replicates imm32[31] up to XLEN-1.
  assign imm = XLEN'(imm32);

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes at the input, then holds results in an
// output register plus an optional skid register for full-rate backpressure.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter bit SKID_EN = 1'b1
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      flush,
  imm_gen_if.slave  bus,
  output state_e    dbg_state
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            illegal;
    logic [31:0]     instr;
  } entry_t;

  state_e          state;
  entry_t          out_q;
  entry_t          skid_q;
  entry_t          dec_e;
  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_ill;
  logic            in_ready_w;
  logic            out_valid_w;
  logic            accept;
  logic            pop;

  imm_decode #(.XLEN(XLEN)) u_dec (
    .instr   (bus.in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_ill)
  );

  assign dec_e = {dec_imm, dec_fmt, dec_ill, bus.in_instr};

  assign out_valid_w = (state != ST_EMPTY);
  // With the skid register, ready depends on state only; without it, the output
  // register can reload in the same cycle it is popped.
  assign in_ready_w  = SKID_EN ? (~reset & (state != ST_TWO))
                               : (~reset & (~out_valid_w | bus.out_ready));
  assign accept      = bus.in_valid & in_ready_w;
  assign pop         = out_valid_w & bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state  <= ST_EMPTY;
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            out_q <= dec_e;
            state <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            out_q <= dec_e;
          end else if (accept) begin
            skid_q <= dec_e;
            state  <= ST_TWO;
          end else if (pop) begin
            state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            out_q <= skid_q;
            state <= ST_ONE;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_w;
  assign bus.out_valid   = out_valid_w;
  assign bus.out_imm     = out_q.imm;
  assign bus.out_fmt     = out_q.fmt;
  assign bus.out_illegal = out_q.illegal;
  assign bus.out_instr   = out_q.instr;
  assign dbg_state       = state;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 64-bit skid instance and a 32-bit no-skid instance,
// checked every cycle against an arithmetic decode model and an occupancy queue.
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic   rst64, rst32, fl64, fl32;
  state_e dbg64, dbg32;

  imm_gen_if #(.XLEN(64)) bus64 ();
  imm_gen_if #(.XLEN(32)) bus32 ();

  imm_gen_pipe #(.XLEN(64), .SKID_EN(1'b1)) u_dut64 (
    .clk(clk), .reset(rst64), .flush(fl64), .bus(bus64.slave), .dbg_state(dbg64)
  );
  imm_gen_pipe #(.XLEN(32), .SKID_EN(1'b0)) u_dut32 (
    .clk(clk), .reset(rst32), .flush(fl32), .bus(bus32.slave), .dbg_state(dbg32)
  );

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [31:0] instr;
  } ent_t;

  ent_t exp64_q[$];
  ent_t exp32_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   acc64   = 0;
  int   acc32   = 0;

  // Immediate from the ISA field layout using plain integer arithmetic.
  function automatic ent_t model_dec(input logic [31:0] ins, input int xlen);
    ent_t   e;
    longint v;
    e       = '0;
    e.instr = ins;
    v       = 0;
    case (ins[6:0])
      7'h03, 7'h13, 7'h1b, 7'h67, 7'h73: begin
        e.fmt = 3'd1;
        v = longint'(ins[31:20]);
        if (v >= 2048) v = v - 4096;
      end
      7'h23: begin
        e.fmt = 3'd2;
        v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
        if (v >= 2048) v = v - 4096;
      end
      7'h63: begin
        e.fmt = 3'd3;
        v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
          + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
        if (v >= 4096) v = v - 8192;
      end
      7'h37, 7'h17: begin
        e.fmt = 3'd4;
        v = longint'(ins[31:12]) * 4096;
        if (v >= 64'sh8000_0000) v = v - 64'sh1_0000_0000;
      end
      7'h6f: begin
        e.fmt = 3'd5;
        v = longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096
          + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
        if (v >= 1048576) v = v - 2097152;
      end
      default: e.ill = 1'b1;
    endcase
    e.imm = (xlen == 32) ? {32'h0, v[31:0]} : v;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  tab [0:11];
    logic [31:0] r;
    tab = '{7'h03, 7'h13, 7'h1b, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h33, 7'h7f};
    r = $urandom();
    r[6:0] = tab[$urandom_range(0, 11)];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic check_side(input string tag, input int cnt, input ent_t head,
                            input logic exp_rdy, input logic rdy, input logic vld,
                            input logic [63:0] imm, input logic [2:0] fmt,
                            input logic ill, input logic [31:0] ins);
    chk({tag, "_in_ready"}, 64'(rdy), 64'(exp_rdy));
    chk({tag, "_out_valid"}, 64'(vld), 64'(cnt > 0));
    if (cnt > 0) begin
      chk({tag, "_out_imm"}, imm, head.imm);
      chk({tag, "_out_fmt"}, 64'(fmt), 64'(head.fmt));
      chk({tag, "_out_illegal"}, 64'(ill), 64'(head.ill));
      chk({tag, "_out_instr"}, 64'(ins), 64'(head.instr));
    end
  endtask

  function automatic logic exp_rdy64();
    return !rst64 && (exp64_q.size() < 2);
  endfunction

  function automatic logic exp_rdy32();
    return !rst32 && (exp32_q.size() == 0 || bus32.out_ready);
  endfunction

  // Compare, then advance the model for the coming rising edge.
  always @(negedge clk) begin
    check_side("d64", exp64_q.size(), (exp64_q.size() > 0) ? exp64_q[0] : ent_t'(0),
               exp_rdy64(), bus64.in_ready, bus64.out_valid, bus64.out_imm,
               bus64.out_fmt, bus64.out_illegal, bus64.out_instr);
    check_side("d32", exp32_q.size(), (exp32_q.size() > 0) ? exp32_q[0] : ent_t'(0),
               exp_rdy32(), bus32.in_ready, bus32.out_valid, 64'(bus32.out_imm),
               bus32.out_fmt, bus32.out_illegal, bus32.out_instr);
    if (rst64 || fl64) begin
      exp64_q.delete();
    end else begin
      if (bus64.in_valid && exp_rdy64()) begin
        if (exp64_q.size() > 0 && bus64.out_ready) void'(exp64_q.pop_front());
        exp64_q.push_back(model_dec(bus64.in_instr, 64));
        acc64++;
      end else if (exp64_q.size() > 0 && bus64.out_ready) begin
        void'(exp64_q.pop_front());
      end
    end
    if (rst32 || fl32) begin
      exp32_q.delete();
    end else begin
      if (bus32.in_valid && exp_rdy32()) begin
        if (exp32_q.size() > 0 && bus32.out_ready) void'(exp32_q.pop_front());
        exp32_q.push_back(model_dec(bus32.in_instr, 32));
        acc32++;
      end else if (exp32_q.size() > 0 && bus32.out_ready) begin
        void'(exp32_q.pop_front());
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the word was taken.
  task automatic push64(input logic [31:0] ins);
    int k;
    k = 0;
    bus64.in_valid = 1'b1;
    bus64.in_instr = ins;
    @(negedge clk);
    while (!bus64.in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) begin
      n_tests++;
      n_fail++;
      $display("FAIL push64_timeout: in_ready=%0b, expected 1 within 20 cycles", bus64.in_ready);
    end
    @(posedge clk); #1;
    bus64.in_valid = 1'b0;
  endtask

  // Both instances, out_ready=1: one-cycle latency checked against literals.
  task automatic send2(input logic [31:0] ins, input logic [63:0] ei,
                       input logic [2:0] ef, input logic el);
    bus64.in_valid = 1'b1; bus64.in_instr = ins;
    bus32.in_valid = 1'b1; bus32.in_instr = ins;
    @(posedge clk); #1;
    bus64.in_valid = 1'b0;
    bus32.in_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("lit64_valid_%h", ins), 64'(bus64.out_valid), 64'd1);
    chk($sformatf("lit64_imm_%h", ins), bus64.out_imm, ei);
    chk($sformatf("lit64_fmt_%h", ins), 64'(bus64.out_fmt), 64'(ef));
    chk($sformatf("lit64_ill_%h", ins), 64'(bus64.out_illegal), 64'(el));
    chk($sformatf("lit32_imm_%h", ins), 64'(bus32.out_imm), {32'h0, ei[31:0]});
    chk($sformatf("lit32_fmt_%h", ins), 64'(bus32.out_fmt), 64'(ef));
    @(posedge clk); #1;
  endtask

  initial begin
    logic a64, a32;
    int   cyc;
    rst64 = 1'b1; rst32 = 1'b1; fl64 = 1'b0; fl32 = 1'b0;
    bus64.in_valid = 1'b0; bus64.in_instr = '0; bus64.out_ready = 1'b0;
    bus32.in_valid = 1'b0; bus32.in_instr = '0; bus32.out_ready = 1'b0;

    // Pin the model on the documented vectors.
    chk("model_addi", model_dec(32'hFFF00093, 64).imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("model_beq",  model_dec(32'hFE000EE3, 64).imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("model_jal",  model_dec(32'h001000EF, 64).imm, 64'h0000_0000_0000_0800);
    chk("model_lui32", model_dec(32'h800000B7, 32).imm, 64'h0000_0000_8000_0000);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(bus64.in_ready), 64'd0);
    chk("rst_out_imm", bus64.out_imm, 64'd0);
    chk("rst_out_fmt", 64'(bus64.out_fmt), 64'd0);
    chk("rst_out_instr", 64'(bus64.out_instr), 64'd0);
    @(posedge clk); #1;
    rst64 = 1'b0; rst32 = 1'b0;
    bus64.out_ready = 1'b1; bus32.out_ready = 1'b1;
    @(posedge clk); #1;

    send2(32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
    send2(32'h00512423, 64'h0000_0000_0000_0008, 3'd2, 1'b0);
    send2(32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0);
    send2(32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0);
    send2(32'h001000EF, 64'h0000_0000_0000_0800, 3'd5, 1'b0);
    send2(32'h0000007F, 64'h0, 3'd0, 1'b1);
    send2(32'h00000033, 64'h0, 3'd0, 1'b1);

    // Backpressure: A and B fill both slots, C must stall.
    bus64.out_ready = 1'b0;
    push64(32'h00100093);
    push64(32'h00200113);
    bus64.in_valid = 1'b1; bus64.in_instr = 32'h00300193;
    @(negedge clk);
    chk("bp_in_ready_c", 64'(bus64.in_ready), 64'd0);
    chk("bp_head_a", 64'(bus64.out_instr), 64'h00100093);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_in_ready_hold", 64'(bus64.in_ready), 64'd0);
    @(posedge clk); #1;
    bus64.out_ready = 1'b1;
    push64(32'h00300193);
    repeat (4) @(posedge clk);
    #1;

    // Flush in TWO together with a new input.
    bus64.out_ready = 1'b0;
    push64(32'h00400213);
    push64(32'h00500293);
    chk("fl_pre_two", 64'(dbg64), 64'(ST_TWO));
    bus64.in_valid = 1'b1; bus64.in_instr = 32'h00600313; fl64 = 1'b1;
    @(posedge clk); #1;
    fl64 = 1'b0; bus64.in_valid = 1'b0;
    @(negedge clk);
    chk("fl_out_valid", 64'(bus64.out_valid), 64'd0);
    chk("fl_in_ready", 64'(bus64.in_ready), 64'd1);
    chk("fl_out_imm", bus64.out_imm, 64'd0);
    chk("fl_out_instr", 64'(bus64.out_instr), 64'd0);
    @(posedge clk); #1;
    bus64.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset in TWO.
    bus64.out_ready = 1'b0;
    push64(32'h00700393);
    push64(32'h00800413);
    rst64 = 1'b1;
    bus64.in_valid = 1'b1; bus64.in_instr = 32'h00900493;
    @(negedge clk);
    chk("rst2_in_ready", 64'(bus64.in_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst2_in_ready_hold", 64'(bus64.in_ready), 64'd0);
    @(posedge clk); #1;
    rst64 = 1'b0; bus64.in_valid = 1'b0;
    @(negedge clk);
    chk("rst2_out_valid", 64'(bus64.out_valid), 64'd0);
    chk("rst2_out_imm", bus64.out_imm, 64'd0);
    chk("rst2_out_fmt", 64'(bus64.out_fmt), 64'd0);
    chk("rst2_out_illegal", 64'(bus64.out_illegal), 64'd0);
    chk("rst2_out_instr", 64'(bus64.out_instr), 64'd0);
    chk("rst2_in_ready_after", 64'(bus64.in_ready), 64'd1);
    @(posedge clk); #1;

    // Random stalls and occasional flushes on both instances.
    acc64 = 0;
    cyc = 0;
    while (acc64 < 10000 && cyc < 40000) begin
      @(negedge clk);
      a64 = bus64.in_valid && bus64.in_ready;
      a32 = bus32.in_valid && bus32.in_ready;
      @(posedge clk); #1;
      if (!bus64.in_valid || a64 || fl64) begin
        bus64.in_valid = ($urandom_range(0, 3) != 0);
        bus64.in_instr = rand_instr();
      end
      if (!bus32.in_valid || a32 || fl32) begin
        bus32.in_valid = ($urandom_range(0, 3) != 0);
        bus32.in_instr = rand_instr();
      end
      bus64.out_ready = ($urandom_range(0, 3) != 0);
      bus32.out_ready = ($urandom_range(0, 2) != 0);
      fl64 = ($urandom_range(0, 499) == 0);
      fl32 = ($urandom_range(0, 499) == 0);
      cyc++;
    end
    bus64.in_valid = 1'b0; bus32.in_valid = 1'b0;
    fl64 = 1'b0; fl32 = 1'b0;
    bus64.out_ready = 1'b1; bus32.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rand_accepted_10k", 64'(acc64 >= 10000), 64'd1);
    chk("rand_drained64", 64'(bus64.out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
